mem_arbiter: RTL

Two-master arbiter placed in front of the main memory slave on the uib bus. Master 0 is instruction fetch and master 1 is load/store. The arbiter issues at most one memory access per cycle and selects between the masters by round robin. It tracks the one-cycle read latency and routes each response back to its issuer. It also provides a lock mechanism so one master can perform an atomic read-modify-write sequence without interleaving.

---
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter in front of the main memory slave.
// Master 0 is instruction fetch, master 1 is load/store. At most one access is issued
// per cycle, a lock lets one master run an uninterrupted read-modify-write, and the
// one-cycle read response is routed back to the master that issued it.
module mem_arbiter #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MODE_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic                  m0_wen,
    input  logic                  m0_lock,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [MODE_WIDTH-1:0] m0_mode,
    input  logic [XLEN-1:0]       m0_dat_i,
    output logic                  m0_gnt,
    output logic                  m0_valid,
    output logic [XLEN-1:0]       m0_dat_o,

    input  logic                  m1_req,
    input  logic                  m1_wen,
    input  logic                  m1_lock,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [MODE_WIDTH-1:0] m1_mode,
    input  logic [XLEN-1:0]       m1_dat_i,
    output logic                  m1_gnt,
    output logic                  m1_valid,
    output logic [XLEN-1:0]       m1_dat_o,

    output logic                  mem_req,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [MODE_WIDTH-1:0] mem_mode,
    output logic [XLEN-1:0]       mem_dat_o,
    input  logic [XLEN-1:0]       mem_dat_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   ptr_q,   ptr_d;     // master that wins a tie in IDLE (0 or 1)
    logic   pend_q,  pend_d;    // a response is due this cycle
    logic   owner_q, owner_d;   // master the pending response belongs to
    logic   rd_q,    rd_d;      // pending response is for a read

    logic   gnt0, gnt1;

    // State register, round-robin pointer and response tag
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            pend_q  <= 1'b0;
            owner_q <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
            owner_q <= owner_d;
            rd_q    <= rd_d;
        end
    end

    // Next state: enter a lock on a locked grant from IDLE, leave when the owner drops lock
    // NOTE: every combinational output gets a default before the case, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (gnt0 && m0_lock) begin
                    state_d = LOCK0;
                end else if (gnt1 && m1_lock) begin
                    state_d = LOCK1;
                end
            end
            LOCK0:   if (!m0_lock) state_d = IDLE;
            LOCK1:   if (!m1_lock) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant decode: single requester wins, a tie goes to the pointer, a lock admits only its owner
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        // Grants are suppressed while reset is held so every output reads 0 in reset.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (m0_req && m1_req) begin
                        gnt0 = ~ptr_q;
                        gnt1 = ptr_q;
                    end else begin
                        gnt0 = m0_req;
                        gnt1 = m1_req;
                    end
                end
                LOCK0:   gnt0 = m0_req;
                LOCK1:   gnt1 = m1_req;
                default: ;
            endcase
        end
    end

    // Pointer and response-tag update: pointer flips on IDLE grants and freezes inside a lock
    always_comb begin
        ptr_d = ptr_q;
        if ((state_q == IDLE) && (gnt0 || gnt1)) begin
            ptr_d = gnt0;   // after a master-0 grant, master 1 wins the next tie
        end
        pend_d  = gnt0 | gnt1;
        owner_d = gnt1;
        if (gnt0) begin
            rd_d = ~m0_wen;
        end else if (gnt1) begin
            rd_d = ~m1_wen;
        end else begin
            rd_d = 1'b0;
        end
    end

    // Issue path: memory command muxed from the granted master, all zero when idle
    always_comb begin
        mem_req   = gnt0 | gnt1;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_mode  = '0;
        mem_dat_o = '0;
        if (gnt0) begin
            mem_wen   = m0_wen;
            mem_addr  = m0_addr;
            mem_mode  = m0_mode;
            mem_dat_o = m0_dat_i;
        end else if (gnt1) begin
            mem_wen   = m1_wen;
            mem_addr  = m1_addr;
            mem_mode  = m1_mode;
            mem_dat_o = m1_dat_i;
        end
    end

    // Response path: valid to the tagged owner, read data only for a tagged read
    always_comb begin
        m0_valid = pend_q & ~owner_q;
        m1_valid = pend_q &  owner_q;
        m0_dat_o = (m0_valid && rd_q) ? mem_dat_i : '0;
        m1_dat_o = (m1_valid && rd_q) ? mem_dat_i : '0;
    end

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;

endmodule
